fifo_buffer: RTL and testbench
==============================

# fifo_buffer

Fixed-latency delay line: every cycle it accepts one WIDTH-bit sample and presents the sample accepted exactly DEPTH cycles earlier. It is the line buffer of the feature-tracking pipeline. In non-maximal suppression, each window row is delayed by (image width − window size) pixels, so the next window row lines up column-for-column. There is no handshake; the block is free-running, one sample per clock.

## Interface
- WIDTH, default 8: bit width of each sample.
- DEPTH, default 633: delay in clock cycles. Must be ≥ 1; elaboration fails otherwise.
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  reset, synchronous and active-high.
- data_in  input  WIDTH  sample sampled on every rising clk edge.
- data_out  output  WIDTH  delayed sample, registered.

## Operation
- Transfer function: with cycle c meaning the interval after the c-th rising edge, data_out in cycle c equals data_in in cycle c−DEPTH.
- No enable and no stall: a sample is written and a sample is read every cycle.
- Cold start: every stored position reads as 0.
  - After power-up, data_out is 0 until the first real sample has propagated through.
  - After a reset, data_out is likewise 0 until the first post-reset sample has propagated through.
- Implementation choice is fixed by DEPTH:
  - DEPTH ≤ 4: a chain of DEPTH registers.
  - DEPTH > 4: a ring buffer of DEPTH−1 entries plus the output register.
    - A single pointer ptr, width $clog2(DEPTH−1) (minimum 1), selects the entry.
    - Each cycle the entry at ptr is read into data_out, and in the same cycle data_in is written into that same entry (read-before-write).
    - ptr increments and wraps from DEPTH−2 to 0.
- Zero-masking for the ring buffer: the RAM contents are not cleared.
  - A fill counter counts samples written since reset and saturates at DEPTH−1.
  - While the counter is below DEPTH−1, the value loaded into data_out is forced to 0.
- Values pass through unmodified. There is no arithmetic; the full WIDTH is preserved, including all-ones.

## Timing
- Reset (rst high at an edge):
  - data_out ← 0, ptr ← 0, fill counter ← 0.
  - In the register variant, all stages ← 0.
  - data_in presented in a cycle where rst is high is discarded.
- First valid output after reset: the sample presented in the first cycle with rst low appears on data_out exactly DEPTH cycles later. All cycles before that show 0.
- Reset asserted mid-stream:
  - Takes effect at the next edge.
  - All in-flight samples are lost.
  - data_out reads 0 for the next DEPTH cycles after rst deasserts.
- Power-up without reset: data_out and all register stages initialise to 0 via initial values. In the ring variant the fill counter initialises to 0, so outputs are masked until the buffer fills.
- Wrap-around: ptr rollover must cause no bubble and no duplicate sample; latency stays exactly DEPTH across the wrap.
- Throughput: 1 sample per clock, sustained indefinitely.

## Structure
- No shared package is required. The pointer width is a localparam computed with $clog2.
- One sub-module: delay_ram.
  - Single-clock RAM, depth DEPTH−1, width WIDTH.
  - Synchronous read, read-old-data on same-address write.
  - Written so that synthesis infers block RAM.
  - Used only in the DEPTH > 4 variant.
- The generate branch selecting the register or ring variant lives in fifo_buffer. Control logic (ptr, fill counter, masking) also lives in fifo_buffer.

## Test plan
- WIDTH=8, DEPTH=633, reset, then ramp data_in = 1,2,3,…: data_out = 0 for cycles 1..632 after reset, 1 at cycle 633, then increments by 1 each cycle through the pointer wrap.
- DEPTH=1: data_in sequence 5, 9, 0xFF → data_out shows 5, 9, 0xFF, each one cycle later.
- DEPTH=3 (register variant) and DEPTH=5 (ring variant, smallest ring), random stimulus: data_out matches a scoreboard of data_in delayed by DEPTH for 10,000 cycles.
- Mid-stream reset, DEPTH=633: stream 0xAA for 1,000 cycles, pulse rst for 1 cycle, then stream 0x55.
  - data_out = 0 for 633 cycles after rst deasserts, then 0x55.
  - No 0xAA may appear after the reset.
- Power-up without reset, DEPTH=8: data_in constant 0x3C → data_out 0 for 8 cycles, then 0x3C.
- WIDTH=16, DEPTH=7: alternating 0x0000/0xFFFF → data_out reproduces the pattern with exact 7-cycle lag, no bit corruption.

Source files
------------

// File: rtl/fifo_buffer_pkg.sv
// fifo_buffer_pkg: shared constants and helpers for the fifo_buffer delay line.
//   REG_MAX_DEPTH : largest delay built as a plain register chain; deeper
//                   delays use a RAM ring buffer.
//   ptr_width()   : address width for a ring of a given entry count (min 1).
package fifo_buffer_pkg;

  localparam int REG_MAX_DEPTH = 4;

  function automatic int ptr_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/fifo_buffer_if.sv
// fifo_buffer_if: sample stream into and out of the delay line.
//   data_in  : sample presented every cycle (driven by master)
//   data_out : sample delayed by DEPTH cycles (driven by slave / the buffer)
interface fifo_buffer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (output data_in, input  data_out);
  modport slave  (input  data_in, output data_out);
endinterface

// File: rtl/fifo_buffer_delay_ram.sv
// delay_ram: single-clock simple RAM for the ring variant of fifo_buffer.
//   clk      : clock
//   we_i     : write enable for wdata_i at addr_i
//   addr_i   : shared read/write address
//   wdata_i  : write data
//   rd_clr_i : synchronous clear of the read register (masks stale contents)
//   rdata_o  : registered read data, old contents on same-address write
// The read register doubles as the delay line's output register, and its
// synchronous clear maps onto the block-RAM output-register reset.
module delay_ram #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 4,
  parameter int AW      = 2
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_clr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] rdata_q = '0;

  // Memory contents are never cleared; zero-masking is done on the read side.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Non-blocking read of the same address returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (rd_clr_i) rdata_q <= '0;
    else          rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: free-running fixed-latency delay line, one sample per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : fifo_buffer_if.slave; data_out(c) = data_in(c-DEPTH), zero on cold start
// DEPTH <= REG_MAX_DEPTH builds a register chain; larger DEPTH builds a ring of
// DEPTH-1 RAM entries whose read register is the output stage.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 633
) (
  input  logic          clk,
  input  logic          rst,
  fifo_buffer_if.slave  bus
);

  if (DEPTH < 1) begin : g_bad
    $error("fifo_buffer: DEPTH must be >= 1");
  end else if (DEPTH <= REG_MAX_DEPTH) begin : g_reg

    logic [DEPTH-1:0][WIDTH-1:0] stg_q = '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        stg_q <= '0;
      end else begin
        stg_q[0] <= bus.data_in;
        for (int i = 1; i < DEPTH; i++) stg_q[i] <= stg_q[i-1];
      end
    end

    assign bus.data_out = stg_q[DEPTH-1];

  end else begin : g_ring

    localparam int ENTRIES = DEPTH - 1;
    localparam int PTR_W   = ptr_width(ENTRIES);
    localparam int FILL_W  = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(ENTRIES - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(ENTRIES);

    logic [PTR_W-1:0]  ptr_q = '0;
    logic [PTR_W-1:0]  ptr_d;
    logic [FILL_W-1:0] fill_q = '0;
    logic [FILL_W-1:0] fill_d;
    logic              full;

    // A sample written at ptr comes back round after ENTRIES edges; until the
    // ring has been written ENTRIES times since reset the entry under ptr is
    // stale (pre-reset or power-up garbage), so the read is forced to 0.
    always_comb begin
      full   = (fill_q == FILL_FULL);
      ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      fill_d = full ? fill_q : fill_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_q  <= '0;
        fill_q <= '0;
      end else begin
        ptr_q  <= ptr_d;
        fill_q <= fill_d;
      end
    end

    delay_ram #(
      .WIDTH   (WIDTH),
      .ENTRIES (ENTRIES),
      .AW      (PTR_W)
    ) u_ram (
      .clk      (clk),
      .we_i     (~rst),
      .addr_i   (ptr_q),
      .wdata_i  (bus.data_in),
      .rd_clr_i (rst | ~full),
      .rdata_o  (bus.data_out)
    );

  end

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: six delay-line configurations driven side by side; a per-
// instance queue model supplies the expected output every cycle, plus directed
// checks at the latency, reset and power-up boundaries.
module tb_fifo_buffer;

  localparam int N = 6;
  // index: 0=W8/D633 1=W8/D1 2=W8/D3 3=W8/D5 4=W8/D8 (never reset) 5=W16/D7
  localparam int DEP [N] = '{633, 1, 3, 5, 8, 7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] din  [N];
  logic [15:0] dout [N];
  logic        rstv [N];

  fifo_buffer_if #(.WIDTH(8))  bus0 ();
  fifo_buffer_if #(.WIDTH(8))  bus1 ();
  fifo_buffer_if #(.WIDTH(8))  bus2 ();
  fifo_buffer_if #(.WIDTH(8))  bus3 ();
  fifo_buffer_if #(.WIDTH(8))  bus4 ();
  fifo_buffer_if #(.WIDTH(16)) bus5 ();

  assign bus0.data_in = din[0][7:0];
  assign bus1.data_in = din[1][7:0];
  assign bus2.data_in = din[2][7:0];
  assign bus3.data_in = din[3][7:0];
  assign bus4.data_in = din[4][7:0];
  assign bus5.data_in = din[5];
  assign dout[0] = {8'h00, bus0.data_out};
  assign dout[1] = {8'h00, bus1.data_out};
  assign dout[2] = {8'h00, bus2.data_out};
  assign dout[3] = {8'h00, bus3.data_out};
  assign dout[4] = {8'h00, bus4.data_out};
  assign dout[5] = bus5.data_out;

  fifo_buffer #(.WIDTH(8),  .DEPTH(633)) u0 (.clk(clk), .rst(rstv[0]), .bus(bus0));
  fifo_buffer #(.WIDTH(8),  .DEPTH(1))   u1 (.clk(clk), .rst(rstv[1]), .bus(bus1));
  fifo_buffer #(.WIDTH(8),  .DEPTH(3))   u2 (.clk(clk), .rst(rstv[2]), .bus(bus2));
  fifo_buffer #(.WIDTH(8),  .DEPTH(5))   u3 (.clk(clk), .rst(rstv[3]), .bus(bus3));
  fifo_buffer #(.WIDTH(8),  .DEPTH(8))   u4 (.clk(clk), .rst(rstv[4]), .bus(bus4));
  fifo_buffer #(.WIDTH(16), .DEPTH(7))   u5 (.clk(clk), .rst(rstv[5]), .bus(bus5));

  int          checks;
  int          errors;
  int          ncyc;
  int          aa_seen;
  int          nz;
  logic        post_rst;
  logic [15:0] mq [N][$];
  logic [15:0] ex [N];
  logic [15:0] seq1 [3] = '{16'h0005, 16'h0009, 16'h00FF};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    mq[k].delete();
    for (int j = 0; j < DEP[k] - 1; j++) mq[k].push_back(16'h0000);
  endtask

  // One clock: model every instance at the edge, compare just after it.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (rstv[k]) begin
        model_reset(k);
        ex[k] = 16'h0000;
      end else begin
        mq[k].push_back(din[k]);
        ex[k] = mq[k].pop_front();
      end
    end
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      assert (dout[k] === ex[k]) else begin
        errors++;
        $error("FAIL sb_d%0d got %h exp %h", DEP[k], dout[k], ex[k]);
      end
    end
    if (post_rst && dout[0][7:0] == 8'hAA) aa_seen++;
    ncyc++;
  endtask

  task automatic rnd();
    din[1] = 16'($urandom_range(0, 255));
    din[2] = 16'($urandom_range(0, 255));
    din[3] = 16'($urandom_range(0, 255));
  endtask

  initial begin
    checks = 0; errors = 0; ncyc = 0; aa_seen = 0; post_rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      din[k]  = 16'h0000;
      rstv[k] = (k != 4);
      model_reset(k);
    end
    din[4] = 16'h003C;

    // Power-up state before any edge.
    #1;
    for (int k = 0; k < N; k++) chk("powerup_zero", dout[k], 0);

    step(); step();
    for (int k = 0; k < N; k++) if (k != 4) rstv[k] = 1'b0;

    // Ramp through D633 (past the pointer wrap), D1 sequence, 16-bit alternation.
    for (int i = 1; i <= 1400; i++) begin
      rnd();
      din[0] = 16'(i & 255);
      if (i <= 3) din[1] = seq1[i-1];
      din[5] = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
      step();
      if (i <= 3)    chk("d1_seq", dout[1], seq1[i-1]);
      if (i == 5)    chk("d8_powerup_masked", dout[4], 0);
      if (i == 6)    chk("d8_powerup_first", dout[4], 32'h3C);
      if (i == 632)  chk("d633_last_zero", dout[0], 0);
      if (i == 633)  chk("d633_first", dout[0], 1);
      if (i == 1400) chk("d633_after_wrap", dout[0], 32'((1400 - 632) & 255));
      if (i == 1400) chk("d7_alt", dout[5], 32'h0000);
    end

    // Mid-stream reset on D633.
    for (int i = 0; i < 1000; i++) begin
      rnd(); din[0] = 16'h00AA; din[5] = 16'($urandom_range(0, 65535));
      step();
    end
    chk("d633_aa_stream", dout[0], 32'hAA);
    rstv[0] = 1'b1;
    step();
    chk("d633_rst_out", dout[0], 0);
    rstv[0] = 1'b0; post_rst = 1'b1; din[0] = 16'h0055;
    nz = 0;
    for (int i = 0; i < 632; i++) begin
      rnd(); step();
      if (dout[0] != 16'h0000) nz++;
    end
    chk("d633_zero_window", nz, 0);
    rnd(); step();
    chk("d633_first_55", dout[0], 32'h55);
    for (int i = 0; i < 200; i++) begin rnd(); step(); end
    chk("d633_no_aa", aa_seen, 0);

    // Random soak for the small register and ring variants.
    while (ncyc < 10100) begin
      rnd(); din[5] = 16'($urandom_range(0, 65535));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
